// File: rtl/lcd_tx_scheduler.sv
// lcd_tx_scheduler: byte scheduler in front of the SPI LCD serializer.
// It arbitrates between a raw command packet stream and a window-update
// engine. A window sends the CASET/RASET/RAMWR header and then RGB565 pixels,
// one byte at a time, over a valid/ready handshake with D/C and end-of-packet
// flags.
// Optional feature: define LCD_OFFSET_EN to add X_OFS/Y_OFS to the CASET/RASET
// coordinates. When it is undefined the offsets are zero.
module lcd_tx_scheduler #(
    parameter int X_OFS = 1,
    parameter int Y_OFS = 26,
    parameter int H_PIX = 160,
    parameter int V_PIX = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_byte,
    input  logic        cmd_dc,
    input  logic        cmd_last,
    input  logic        win_req,
    input  logic [7:0]  win_x0,
    input  logic [7:0]  win_y0,
    input  logic [7:0]  win_x1,
    input  logic [7:0]  win_y1,
    output logic        win_ack,
    output logic        win_err,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_dc,
    output logic        tx_last,
    output logic        busy
);

`ifdef LCD_OFFSET_EN
    localparam int OFS_EN = 1;
`else
    localparam int OFS_EN = 0;
`endif
    localparam logic [7:0] XO    = 8'(X_OFS * OFS_EN);
    localparam logic [7:0] YO    = 8'(Y_OFS * OFS_EN);
    localparam logic [8:0] H_LIM = 9'(H_PIX);
    localparam logic [8:0] V_LIM = 9'(V_PIX);

    typedef enum logic [3:0] {
        IDLE, CMD, CASET_C, CASET_P, RASET_C, RASET_P,
        RAMWR, PIX_LD, PIX_HI, PIX_LO, ACK
    } state_t;

    state_t      state, next_state;
    logic        prio_win;
    logic [7:0]  x0_q, y0_q, x1_q, y1_q;
    logic        err_q;
    logic [1:0]  par_idx;
    logic [13:0] pix_cnt;
    logic [15:0] pix_q;

    logic        tx_free;
    logic        win_legal;
    logic [7:0]  win_w, win_h;
    logic [13:0] win_area;
    logic [7:0]  x_par, y_par;

    logic        grant_cmd, grant_win;
    logic        load;
    logic [7:0]  ld_byte;
    logic        ld_dc, ld_last;
    logic        idx_inc, pix_take, cnt_dec;

    assign tx_free   = !tx_valid || tx_ready;
    assign win_legal = (win_x0 <= win_x1) && (win_y0 <= win_y1) &&
                       ({1'b0, win_x1} < H_LIM) && ({1'b0, win_y1} < V_LIM);
    assign win_w     = win_x1 - win_x0 + 8'd1;
    assign win_h     = win_y1 - win_y0 + 8'd1;
    assign win_area  = 14'(win_w) * 14'(win_h);

    assign cmd_ready = (state == CMD) && tx_free;
    assign pix_ready = (state == PIX_LD);
    assign win_ack   = (state == ACK);
    assign win_err   = (state == ACK) && err_q;
    assign busy      = (state != IDLE) || tx_valid;

    // Pick the CASET/RASET parameter for the current slot: high bytes are zero, low bytes carry the offset coordinate
    always_comb begin
        x_par = 8'h00;
        y_par = 8'h00;
        case (par_idx)
            2'd1: begin
                x_par = x0_q + XO;
                y_par = y0_q + YO;
            end
            2'd3: begin
                x_par = x1_q + XO;
                y_par = y1_q + YO;
            end
            default: ;
        endcase
    end

    // Next-state and byte-load decode; a new byte is posted only when the tx register is empty or draining this cycle
    always_comb begin
        next_state = state;
        grant_cmd  = 1'b0;
        grant_win  = 1'b0;
        load       = 1'b0;
        ld_byte    = 8'h00;
        ld_dc      = 1'b0;
        ld_last    = 1'b0;
        idx_inc    = 1'b0;
        pix_take   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (tx_free) begin
                    if (cmd_valid && (!prio_win || !win_req)) begin
                        grant_cmd  = 1'b1;
                        next_state = CMD;
                    end else if (win_req) begin
                        grant_win = 1'b1;
                        if (win_legal) begin
                            // CASET opcode goes out right at grant, so CASET_C only has to post parameter 0
                            load       = 1'b1;
                            ld_byte    = 8'h2A;
                            ld_last    = 1'b1;
                            next_state = CASET_C;
                        end else begin
                            next_state = ACK;
                        end
                    end
                end
            end
            CMD: begin
                if (cmd_valid && tx_free) begin
                    load    = 1'b1;
                    ld_byte = cmd_byte;
                    ld_dc   = cmd_dc;
                    ld_last = cmd_last;
                    if (cmd_last) next_state = IDLE;
                end
            end
            CASET_C: begin
                if (tx_free) begin
                    load       = 1'b1;
                    ld_byte    = x_par;
                    ld_dc      = 1'b1;
                    ld_last    = 1'b1;
                    idx_inc    = 1'b1;
                    next_state = CASET_P;
                end
            end
            CASET_P: begin
                if (tx_free) begin
                    load    = 1'b1;
                    ld_byte = x_par;
                    ld_dc   = 1'b1;
                    ld_last = 1'b1;
                    idx_inc = 1'b1;
                    if (par_idx == 2'd3) next_state = RASET_C;
                end
            end
            RASET_C: begin
                if (tx_free) begin
                    load       = 1'b1;
                    ld_byte    = 8'h2B;
                    ld_last    = 1'b1;
                    next_state = RASET_P;
                end
            end
            RASET_P: begin
                if (tx_free) begin
                    load    = 1'b1;
                    ld_byte = y_par;
                    ld_dc   = 1'b1;
                    ld_last = 1'b1;
                    idx_inc = 1'b1;
                    if (par_idx == 2'd3) next_state = RAMWR;
                end
            end
            RAMWR: begin
                // RAMWR keeps CSX low so the pixel bytes belong to the same packet
                if (tx_free) begin
                    load       = 1'b1;
                    ld_byte    = 8'h2C;
                    next_state = PIX_LD;
                end
            end
            PIX_LD: begin
                if (pix_valid) begin
                    pix_take   = 1'b1;
                    next_state = PIX_HI;
                end
            end
            PIX_HI: begin
                if (tx_free) begin
                    load       = 1'b1;
                    ld_byte    = pix_q[15:8];
                    ld_dc      = 1'b1;
                    next_state = PIX_LO;
                end
            end
            PIX_LO: begin
                if (tx_free) begin
                    load    = 1'b1;
                    ld_byte = pix_q[7:0];
                    ld_dc   = 1'b1;
                    ld_last = (pix_cnt == 14'd1);
                    cnt_dec = 1'b1;
                    next_state = (pix_cnt == 14'd1) ? ACK : PIX_LD;
                end
            end
            ACK: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Output byte register: holds a byte steady until the serializer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_byte  <= 8'h00;
            tx_dc    <= 1'b0;
            tx_last  <= 1'b0;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_byte  <= ld_byte;
            tx_dc    <= ld_dc;
            tx_last  <= ld_last;
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

    // Per-packet context: arbitration flag, latched window, parameter slot, pixel counter and pixel holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_win <= 1'b0;
            x0_q     <= 8'h00;
            y0_q     <= 8'h00;
            x1_q     <= 8'h00;
            y1_q     <= 8'h00;
            err_q    <= 1'b0;
            par_idx  <= 2'd0;
            pix_cnt  <= 14'd0;
            pix_q    <= 16'h0000;
        end else begin
            if (grant_cmd) prio_win <= 1'b1;
            if (grant_win) begin
                prio_win <= 1'b0;
                x0_q     <= win_x0;
                y0_q     <= win_y0;
                x1_q     <= win_x1;
                y1_q     <= win_y1;
                err_q    <= !win_legal;
                par_idx  <= 2'd0;
                pix_cnt  <= win_area;
            end
            if (idx_inc)  par_idx <= par_idx + 2'd1;
            if (pix_take) pix_q   <= pix_data;
            if (cnt_dec)  pix_cnt <= pix_cnt - 14'd1;
        end
    end

endmodule

// File: tb/tb_lcd_tx_scheduler.sv
// Testbench for lcd_tx_scheduler. It keeps a packet-level model: expected
// bytes and acks are queued from the command/window rules, and a monitor
// compares every accepted tx byte and every win_ack against that model.
`timescale 1ns/1ps
module tb_lcd_tx_scheduler;

`ifdef LCD_OFFSET_EN
    localparam logic [7:0] XO = 8'd1;
    localparam logic [7:0] YO = 8'd26;
`else
    localparam logic [7:0] XO = 8'd0;
    localparam logic [7:0] YO = 8'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [7:0]  cmd_byte = 8'h00;
    logic        cmd_dc = 1'b0, cmd_last = 1'b0;
    logic        win_req = 1'b0;
    logic [7:0]  win_x0 = 8'h00, win_y0 = 8'h00, win_x1 = 8'h00, win_y1 = 8'h00;
    logic        win_ack, win_err;
    logic        pix_valid = 1'b0, pix_ready;
    logic [15:0] pix_data = 16'h0000;
    logic        tx_valid, tx_dc, tx_last, busy;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_byte;

    int          n_checks = 0;
    int          n_fail = 0;
    int          tx_count = 0;
    int          ack_count = 0;
    logic [9:0]  exp_q [$];
    logic        ack_q [$];
    logic [9:0]  cap_q [$];
    logic [9:0]  cmd_pkt [$];
    logic [7:0]  hdr_lit [11];
    bit          stall_mode = 1'b0;
    bit          pix_gaps = 1'b0;
    bit          model_prio = 1'b0;
    int          model_pix = 0;
    int          pix_idx = 0;
    bit          pix_xfer = 1'b0;
    bit          prev_stall = 1'b0;
    logic [9:0]  prev_word = 10'h000;

    lcd_tx_scheduler dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
        .cmd_dc(cmd_dc), .cmd_last(cmd_last),
        .win_req(win_req), .win_x0(win_x0), .win_y0(win_y0),
        .win_x1(win_x1), .win_y1(win_y1),
        .win_ack(win_ack), .win_err(win_err),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
        .tx_dc(tx_dc), .tx_last(tx_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pix_val(input int i);
        return 16'(i * 40503 + 4660);
    endfunction

    function void checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endfunction

    function void reportFail(input string name, input logic [31:0] actual);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: got 0x%0h where nothing was expected at %0t", name, actual, $time);
    endfunction

    // Model: a raw packet is forwarded byte for byte
    function void modelCmd();
        foreach (cmd_pkt[i]) exp_q.push_back(cmd_pkt[i]);
        model_prio = 1'b1;
    endfunction

    // Model: window header, pixels and ack, or a bare error ack for an illegal window
    function void modelWindow(input int x0, input int y0, input int x1, input int y1);
        int n;
        logic [15:0] p;
        model_prio = 1'b0;
        if (x0 > x1 || y0 > y1 || x1 >= 160 || y1 >= 80) begin
            ack_q.push_back(1'b1);
            return;
        end
        exp_q.push_back({2'b01, 8'h2A});
        exp_q.push_back({2'b11, 8'h00});
        exp_q.push_back({2'b11, 8'(x0 + XO)});
        exp_q.push_back({2'b11, 8'h00});
        exp_q.push_back({2'b11, 8'(x1 + XO)});
        exp_q.push_back({2'b01, 8'h2B});
        exp_q.push_back({2'b11, 8'h00});
        exp_q.push_back({2'b11, 8'(y0 + YO)});
        exp_q.push_back({2'b11, 8'h00});
        exp_q.push_back({2'b11, 8'(y1 + YO)});
        exp_q.push_back({2'b00, 8'h2C});
        n = (x1 - x0 + 1) * (y1 - y0 + 1);
        for (int k = 0; k < n; k++) begin
            p = pix_val(model_pix);
            model_pix++;
            exp_q.push_back({2'b10, p[15:8]});
            exp_q.push_back({1'b1, (k == n - 1), p[7:0]});
        end
        ack_q.push_back(1'b0);
    endfunction

    // Compare process: tx bytes, stall stability, acks and busy on every cycle
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            pix_xfer = 1'b0;
        end else begin
            if (prev_stall)
                checkOutput("tx_hold", 32'({tx_valid, tx_dc, tx_last, tx_byte}), 32'({1'b1, prev_word}));
            if (tx_valid) checkOutput("busy_with_tx", 32'(busy), 32'd1);
            if (tx_valid && tx_ready) begin
                cap_q.push_back({tx_dc, tx_last, tx_byte});
                tx_count++;
                if (exp_q.size() == 0) reportFail("tx_unexpected", 32'({tx_dc, tx_last, tx_byte}));
                else checkOutput("tx_word", 32'({tx_dc, tx_last, tx_byte}), 32'(exp_q.pop_front()));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_word = {tx_dc, tx_last, tx_byte};
            if (win_ack) begin
                ack_count++;
                if (ack_q.size() == 0) reportFail("ack_unexpected", 32'(win_err));
                else checkOutput("win_err", 32'(win_err), 32'(ack_q.pop_front()));
            end else if (win_err) begin
                reportFail("err_without_ack", 32'(win_err));
            end
            pix_xfer = pix_valid && pix_ready;
        end
    end

    // Serializer and pixel producer: random stalls and gaps driven just after each edge
    always @(posedge clk) begin
        #1;
        tx_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rst) begin
            pix_idx = 0;
            pix_valid = 1'b0;
        end else begin
            if (pix_xfer) pix_idx++;
            pix_valid = pix_gaps ? ($urandom_range(0, 4) != 0) : 1'b1;
            pix_data = pix_val(pix_idx);
        end
    end

    task applyStimulus(input int limit);
        for (int i = 0; i < cmd_pkt.size(); i++) begin
            int w;
            cmd_valid = 1'b1;
            {cmd_dc, cmd_last, cmd_byte} = cmd_pkt[i];
            w = 0;
            while (1) begin
                @(negedge clk);
                if (cmd_ready) break;
                w++;
                if (w > limit) break;
            end
            if (w > limit) begin
                reportFail("cmd_timeout", 32'(i));
                cmd_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task driveWindow(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] x1,
                     input logic [7:0] y1, input int limit, input bit chk_lat, input bit rej);
        int target, w;
        target = ack_count + 1;
        win_x0 = x0; win_y0 = y0; win_x1 = x1; win_y1 = y1;
        win_req = 1'b1;
        if (chk_lat) begin
            @(negedge clk);
            @(negedge clk);
            if (rej) checkOutput("reject_ack_latency", 32'({win_ack, win_err, tx_valid}), 32'({3'b110}));
            else checkOutput("first_hdr_latency", 32'({tx_valid, tx_dc, tx_last, tx_byte}), 32'({3'b101, 8'h2A}));
        end
        w = 0;
        while (ack_count < target && w <= limit) begin
            @(posedge clk);
            w++;
        end
        if (ack_count < target) reportFail("win_timeout", 32'(w));
        #1 win_req = 1'b0;
    endtask

    task waitDrain(input int limit);
        int w;
        w = 0;
        do begin
            @(posedge clk);
            w++;
        end while ((exp_q.size() != 0 || ack_q.size() != 0 || busy) && w <= limit);
        if (w > limit) reportFail("drain_timeout", 32'(exp_q.size()));
        @(posedge clk);
        #1;
    endtask

    task applyReset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_prio = 1'b0;
        model_pix = 0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int tx_before, acks_before;
`ifdef LCD_OFFSET_EN
        hdr_lit = '{8'h2A, 8'h00, 8'h01, 8'h00, 8'h02, 8'h2B, 8'h00, 8'h1A, 8'h00, 8'h1A, 8'h2C};
`else
        hdr_lit = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2C};
`endif
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_outputs", 32'({tx_valid, tx_byte, tx_dc, tx_last, cmd_ready, pix_ready, win_ack, win_err, busy}), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_busy", 32'({busy, cmd_ready, pix_ready}), 32'd0);

        // Single-byte command packet
        $display("[TB] single command byte");
        @(posedge clk); #1;
        cap_q.delete();
        cmd_pkt = '{{2'b01, 8'h11}};
        modelCmd();
        applyStimulus(100);
        waitDrain(100);
        checkOutput("cmd_count", 32'(cap_q.size()), 32'd1);
        if (cap_q.size() >= 1) checkOutput("cmd_pin", 32'(cap_q[0]), 32'({2'b01, 8'h11}));
        checkOutput("cmd_idle", 32'(busy), 32'd0);

        // Two-pixel window with literal header pins
        $display("[TB] window (0,0)-(1,0)");
        cap_q.delete();
        modelWindow(0, 0, 1, 0);
        driveWindow(8'd0, 8'd0, 8'd1, 8'd0, 200, 1'b1, 1'b0);
        waitDrain(200);
        checkOutput("win2_count", 32'(cap_q.size()), 32'd15);
        if (cap_q.size() == 15) begin
            for (int k = 0; k < 11; k++) checkOutput("hdr_pin", 32'(cap_q[k][7:0]), 32'(hdr_lit[k]));
            checkOutput("ramwr_flags", 32'(cap_q[10][9:8]), 32'd0);
            checkOutput("last_flag", 32'({cap_q[11][8], cap_q[12][8], cap_q[13][8], cap_q[14][8]}), 32'b0001);
        end

        // Rejected windows and a legal corner window
        $display("[TB] window bounds");
        stall_mode = 1'b1;
        tx_before = tx_count;
        modelWindow(5, 0, 4, 0);
        driveWindow(8'd5, 8'd0, 8'd4, 8'd0, 50, 1'b1, 1'b1);
        modelWindow(0, 0, 160, 0);
        driveWindow(8'd0, 8'd0, 8'd160, 8'd0, 50, 1'b1, 1'b1);
        modelWindow(0, 6, 3, 5);
        driveWindow(8'd0, 8'd6, 8'd3, 8'd5, 50, 1'b1, 1'b1);
        modelWindow(0, 0, 3, 80);
        driveWindow(8'd0, 8'd0, 8'd3, 8'd80, 50, 1'b1, 1'b1);
        waitDrain(100);
        checkOutput("reject_no_tx", 32'(tx_count), 32'(tx_before));
        modelWindow(159, 79, 159, 79);
        driveWindow(8'd159, 8'd79, 8'd159, 8'd79, 500, 1'b0, 1'b0);
        waitDrain(200);

        // Simultaneous requests under tx stalls
        $display("[TB] arbitration");
        applyReset();
        cmd_pkt = '{{2'b00, 8'h36}, {2'b11, 8'h60}};
        if (model_prio) begin modelWindow(2, 3, 4, 4); modelCmd(); end
        else begin modelCmd(); modelWindow(2, 3, 4, 4); end
        @(posedge clk); #1;
        fork
            applyStimulus(2000);
            driveWindow(8'd2, 8'd3, 8'd4, 8'd4, 2000, 1'b0, 1'b0);
        join
        waitDrain(500);
        cmd_pkt = '{{2'b01, 8'h29}};
        modelCmd();
        applyStimulus(200);
        waitDrain(200);
        cmd_pkt = '{{2'b00, 8'h3A}, {2'b11, 8'h05}};
        if (model_prio) begin modelWindow(10, 20, 12, 21); modelCmd(); end
        else begin modelCmd(); modelWindow(10, 20, 12, 21); end
        @(posedge clk); #1;
        fork
            applyStimulus(2000);
            driveWindow(8'd10, 8'd20, 8'd12, 8'd21, 2000, 1'b0, 1'b0);
        join
        waitDrain(500);

        // Full screen with pixel gaps
        $display("[TB] full screen");
        stall_mode = 1'b0;
        pix_gaps = 1'b1;
        cap_q.delete();
        tx_before = tx_count;
        modelWindow(0, 0, 159, 79);
        driveWindow(8'd0, 8'd0, 8'd159, 8'd79, 60000, 1'b0, 1'b0);
        waitDrain(200);
        checkOutput("pix_bytes", 32'(tx_count - tx_before - 11), 32'd25600);
        cap_q.delete();

        // Reset in the middle of a window
        $display("[TB] reset mid-stream");
        stall_mode = 1'b1;
        modelWindow(0, 0, 9, 9);
        tx_before = tx_count;
        acks_before = ack_count;
        win_x0 = 8'd0; win_y0 = 8'd0; win_x1 = 8'd9; win_y1 = 8'd9;
        win_req = 1'b1;
        for (int w = 0; w < 2000 && tx_count < tx_before + 20; w++) @(posedge clk);
        if (tx_count < tx_before + 20) reportFail("pre_rst_timeout", 32'(tx_count - tx_before));
        @(posedge clk);
        #3 rst = 1'b1;
        #1 checkOutput("rst_async", 32'({tx_valid, busy, win_ack}), 32'd0);
        exp_q.delete();
        ack_q.delete();
        win_req = 1'b0;
        model_prio = 1'b0;
        model_pix = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        tx_before = tx_count;
        repeat (20) @(posedge clk);
        checkOutput("no_ack_after_rst", 32'(ack_count), 32'(acks_before));
        checkOutput("no_tx_after_rst", 32'(tx_count), 32'(tx_before));
        #1;
        cap_q.delete();
        cmd_pkt = '{{2'b01, 8'h11}};
        modelCmd();
        applyStimulus(200);
        waitDrain(200);
        checkOutput("recover_count", 32'(cap_q.size()), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
